// File: rtl/lfsr_skew_feeder_if.sv
// Bus between the LFSR/array side and the skew feeder.
// The feeder attaches through the slave modport; the driving side uses master.
interface lfsr_skew_feeder_if #(
  parameter int NUM_BITS = 49,
  parameter int ROWS     = 4,
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 16
);
  logic                     i_start;
  logic [CNT_W-1:0]         i_num_vec;
  logic                     i_lfsr_vld;
  logic [NUM_BITS-1:0]      i_lfsr_data;
  logic                     i_lfsr_done;
  logic                     o_lfsr_en;
  logic                     i_ready;
  logic [ROWS-1:0]          o_row_vld;
  logic [ROWS*DATA_W-1:0]   o_row_data;
  logic [CNT_W-1:0]         o_vec_cnt;
  logic                     o_busy;
  logic                     o_done;

  modport slave (
    input  i_start, i_num_vec, i_lfsr_vld, i_lfsr_data, i_lfsr_done, i_ready,
    output o_lfsr_en, o_row_vld, o_row_data, o_vec_cnt, o_busy, o_done
  );

  modport master (
    output i_start, i_num_vec, i_lfsr_vld, i_lfsr_data, i_lfsr_done, i_ready,
    input  o_lfsr_en, o_row_vld, o_row_data, o_vec_cnt, o_busy, o_done
  );
endinterface

// File: rtl/lfsr_skew_feeder.sv
// LFSR-to-systolic-array feeder: slices each LFSR word into ROWS lanes and
// delays lane r by r extra advances so operands arrive on the array diagonal.
//
// state  | meaning
// IDLE   | waiting for i_start
// STREAM | pulling words from the LFSR, one per accept
// DRAIN  | pushing ROWS-1 bubbles so the last word reaches every lane tail
// DONE   | one-cycle completion pulse; chains are flushed here
module lfsr_skew_feeder #(
  parameter int NUM_BITS = 49,
  parameter int ROWS     = 4,
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 16
) (
  input logic                i_clk,
  input logic                i_rst,
  lfsr_skew_feeder_if.slave  bus
);
  localparam int DCW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [DCW-1:0]     drain_cnt_q, drain_cnt_d;
  logic               advance, accept, last_accept, flush;
  logic [ROWS-1:0]        row_vld;
  logic [ROWS*DATA_W-1:0] row_data;

  assign advance     = bus.i_ready && ((state_q == STREAM) || (state_q == DRAIN));
  assign accept      = advance && (state_q == STREAM) && bus.i_lfsr_vld;
  assign last_accept = accept &&
                       (((vec_cnt_q + CNT_W'(1)) == target_q) || bus.i_lfsr_done);
  // The final word sits at the lane ROWS-1 tail during DONE; clear it there so
  // no stale valid lingers into IDLE.
  assign flush       = (state_q == DONE);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.i_start) state_d = (bus.i_num_vec != '0) ? STREAM : DONE;
      STREAM:  if (last_accept) state_d = (ROWS > 1) ? DRAIN : DONE;
      DRAIN:   if (advance && (drain_cnt_q == DCW'(1))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; o_lfsr_en also follows i_ready directly
  always_comb begin
    bus.o_lfsr_en = (state_q == STREAM) && bus.i_ready;
    bus.o_busy    = (state_q == STREAM) || (state_q == DRAIN);
    bus.o_done    = (state_q == DONE);
  end

  // Vector count, burst target and drain down-counter next values
  always_comb begin
    vec_cnt_d   = vec_cnt_q;
    target_d    = target_q;
    drain_cnt_d = drain_cnt_q;
    if ((state_q == IDLE) && bus.i_start) begin
      vec_cnt_d = '0;
      target_d  = bus.i_num_vec;
    end
    if (accept) vec_cnt_d = vec_cnt_q + CNT_W'(1);
    if (last_accept)                        drain_cnt_d = DCW'(ROWS - 1);
    else if ((state_q == DRAIN) && advance) drain_cnt_d = drain_cnt_q - DCW'(1);
  end

  // Counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vec_cnt_q   <= '0;
      target_q    <= '0;
      drain_cnt_q <= '0;
    end else begin
      vec_cnt_q   <= vec_cnt_d;
      target_q    <= target_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [r:0]        vld_q;
    logic [DATA_W-1:0] dat_q [r+1];
    logic [DATA_W-1:0] head_dat;

    // Bubbles carry zero data so idle lanes present a clean operand
    assign head_dat = accept ? bus.i_lfsr_data[r*DATA_W +: DATA_W] : '0;

    // Skew chain of depth r+1; shifts only on an advance
    always_ff @(posedge i_clk) begin
      if (i_rst || flush) begin
        vld_q <= '0;
        for (int i = 0; i <= r; i++) dat_q[i] <= '0;
      end else if (advance) begin
        vld_q[0] <= accept;
        dat_q[0] <= head_dat;
        for (int i = 1; i <= r; i++) begin
          vld_q[i] <= vld_q[i-1];
          dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign row_vld[r]                    = vld_q[r];
    assign row_data[r*DATA_W +: DATA_W]  = dat_q[r];
  end

  if (NUM_BITS > ROWS*DATA_W) begin : g_hi_bits
    logic unused_hi;
    assign unused_hi = ^bus.i_lfsr_data[NUM_BITS-1:ROWS*DATA_W];
  end

  assign bus.o_row_vld  = row_vld;
  assign bus.o_row_data = row_data;
  assign bus.o_vec_cnt  = vec_cnt_q;
endmodule

// File: tb/tb_lfsr_skew_feeder.sv
// Directed bench for lfsr_skew_feeder (ROWS=4, DATA_W=8). Each scenario is a
// per-cycle table of inputs and hand-derived outputs sampled on the falling edge.
module tb_lfsr_skew_feeder;
  localparam int NB = 49;
  localparam int RW = 4;
  localparam int DW = 8;
  localparam int CW = 16;

  localparam logic [31:0] W0 = 32'h03020100;
  localparam logic [31:0] W1 = 32'h13121110;
  localparam logic [31:0] W2 = 32'h23222120;
  localparam logic [31:0] W3 = 32'h33323130;

  typedef struct {
    logic        rs;
    logic        st;
    logic [15:0] nv;
    logic        vl;
    logic [31:0] w;
    logic        rd;
    logic        ld;
    logic [3:0]  ev;
    logic [31:0] ed;
    logic [15:0] ec;
    logic        een;
    logic        eb;
    logic        edn;
  } step_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  step_t steps[$];

  always #5 clk = ~clk;

  lfsr_skew_feeder_if #(.NUM_BITS(NB), .ROWS(RW), .DATA_W(DW), .CNT_W(CW)) bus_if ();

  lfsr_skew_feeder #(.NUM_BITS(NB), .ROWS(RW), .DATA_W(DW), .CNT_W(CW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  function automatic step_t mk(input logic rs, input logic st, input logic [15:0] nv,
                               input logic vl, input logic [31:0] w, input logic rd,
                               input logic ld, input logic [3:0] ev, input logic [31:0] ed,
                               input logic [15:0] ec, input logic een, input logic eb,
                               input logic edn);
    step_t s;
    s.rs = rs; s.st = st; s.nv = nv; s.vl = vl; s.w = w; s.rd = rd; s.ld = ld;
    s.ev = ev; s.ed = ed; s.ec = ec; s.een = een; s.eb = eb; s.edn = edn;
    return s;
  endfunction

  task automatic drive(input step_t s);
    rst                = s.rs;
    bus_if.i_start     = s.st;
    bus_if.i_num_vec   = s.nv;
    bus_if.i_lfsr_vld  = s.vl;
    bus_if.i_lfsr_data = {17'h1ABCD, s.w};
    bus_if.i_ready     = s.rd;
    bus_if.i_lfsr_done = s.ld;
  endtask

  task automatic test_reset();
    drive(mk(1, 1, 16'd3, 1, W0, 1, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({bus_if.o_row_vld, bus_if.o_row_data, bus_if.o_vec_cnt, bus_if.o_lfsr_en,
         bus_if.o_busy, bus_if.o_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vld=%b data=%h cnt=%0d en=%b busy=%b done=%b, want all 0",
               bus_if.o_row_vld, bus_if.o_row_data, bus_if.o_vec_cnt, bus_if.o_lfsr_en,
               bus_if.o_busy, bus_if.o_done);
    end
    @(posedge clk); #1;
    drive(mk(0, 0, 16'd0, 1, W1, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    n_checks++;
    if ({bus_if.o_lfsr_en, bus_if.o_busy, bus_if.o_done, bus_if.o_row_vld} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got en=%b busy=%b done=%b vld=%b, want 0 0 0 0000",
               bus_if.o_lfsr_en, bus_if.o_busy, bus_if.o_done, bus_if.o_row_vld);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_skew();
    steps = {};
    steps.push_back(mk(0,1,16'd3,0,0, 1,0, 4'b0000,32'h00000000,16'd0,0,0,0));
    steps.push_back(mk(0,0,16'd0,1,W0,1,0, 4'b0000,32'h00000000,16'd0,1,1,0));
    steps.push_back(mk(0,0,16'd0,1,W1,1,0, 4'b0001,32'h00000000,16'd1,1,1,0));
    steps.push_back(mk(0,0,16'd0,1,W2,1,0, 4'b0011,32'h00000110,16'd2,1,1,0));
    steps.push_back(mk(0,0,16'd0,1,W3,1,0, 4'b0111,32'h00021120,16'd3,0,1,0));
    steps.push_back(mk(0,0,16'd0,1,W3,1,0, 4'b1110,32'h03122100,16'd3,0,1,0));
    steps.push_back(mk(0,0,16'd0,1,W3,1,0, 4'b1100,32'h13220000,16'd3,0,1,0));
    steps.push_back(mk(0,0,16'd0,1,W3,1,0, 4'b1000,32'h23000000,16'd3,0,0,1));
    steps.push_back(mk(0,0,16'd0,0,0, 1,0, 4'b0000,32'h00000000,16'd3,0,0,0));
    foreach (steps[k]) begin
      drive(steps[k]);
      @(negedge clk);
      n_checks++;
      if ({bus_if.o_row_vld, bus_if.o_row_data} !== {steps[k].ev, steps[k].ed}) begin
        n_fail++;
        $display("FAIL basic_skew lanes cyc %0d: got vld=%b data=%h, want vld=%b data=%h",
                 k, bus_if.o_row_vld, bus_if.o_row_data, steps[k].ev, steps[k].ed);
      end
      n_checks++;
      if ({bus_if.o_vec_cnt, bus_if.o_lfsr_en, bus_if.o_busy, bus_if.o_done} !==
          {steps[k].ec, steps[k].een, steps[k].eb, steps[k].edn}) begin
        n_fail++;
        $display("FAIL basic_skew ctrl cyc %0d: got cnt=%0d en=%b busy=%b done=%b, want cnt=%0d en=%b busy=%b done=%b",
                 k, bus_if.o_vec_cnt, bus_if.o_lfsr_en, bus_if.o_busy, bus_if.o_done,
                 steps[k].ec, steps[k].een, steps[k].eb, steps[k].edn);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    steps = {};
    steps.push_back(mk(0,1,16'd3,0,0, 1,0, 4'b0000,32'h00000000,16'd3,0,0,0));
    steps.push_back(mk(0,0,16'd0,1,W0,1,0, 4'b0000,32'h00000000,16'd0,1,1,0));
    steps.push_back(mk(0,0,16'd0,1,W1,0,0, 4'b0001,32'h00000000,16'd1,0,1,0));
    steps.push_back(mk(0,0,16'd0,1,W1,0,0, 4'b0001,32'h00000000,16'd1,0,1,0));
    steps.push_back(mk(0,0,16'd0,1,W1,1,0, 4'b0001,32'h00000000,16'd1,1,1,0));
    steps.push_back(mk(0,0,16'd0,1,W2,1,0, 4'b0011,32'h00000110,16'd2,1,1,0));
    steps.push_back(mk(0,0,16'd0,0,0, 1,0, 4'b0111,32'h00021120,16'd3,0,1,0));
    steps.push_back(mk(0,0,16'd0,0,0, 0,0, 4'b1110,32'h03122100,16'd3,0,1,0));
    steps.push_back(mk(0,0,16'd0,0,0, 1,0, 4'b1110,32'h03122100,16'd3,0,1,0));
    steps.push_back(mk(0,0,16'd0,0,0, 1,0, 4'b1100,32'h13220000,16'd3,0,1,0));
    steps.push_back(mk(0,0,16'd0,0,0, 1,0, 4'b1000,32'h23000000,16'd3,0,0,1));
    steps.push_back(mk(0,0,16'd0,0,0, 1,0, 4'b0000,32'h00000000,16'd3,0,0,0));
    foreach (steps[k]) begin
      drive(steps[k]);
      @(negedge clk);
      n_checks++;
      if ({bus_if.o_row_vld, bus_if.o_row_data} !== {steps[k].ev, steps[k].ed}) begin
        n_fail++;
        $display("FAIL backpressure lanes cyc %0d: got vld=%b data=%h, want vld=%b data=%h",
                 k, bus_if.o_row_vld, bus_if.o_row_data, steps[k].ev, steps[k].ed);
      end
      n_checks++;
      if ({bus_if.o_vec_cnt, bus_if.o_lfsr_en, bus_if.o_busy, bus_if.o_done} !==
          {steps[k].ec, steps[k].een, steps[k].eb, steps[k].edn}) begin
        n_fail++;
        $display("FAIL backpressure ctrl cyc %0d: got cnt=%0d en=%b busy=%b done=%b, want cnt=%0d en=%b busy=%b done=%b",
                 k, bus_if.o_vec_cnt, bus_if.o_lfsr_en, bus_if.o_busy, bus_if.o_done,
                 steps[k].ec, steps[k].een, steps[k].eb, steps[k].edn);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lfsr_bubbles();
    steps = {};
    steps.push_back(mk(0,1,16'd2,0,0, 1,0, 4'b0000,32'h00000000,16'd3,0,0,0));
    steps.push_back(mk(0,0,16'd0,1,W0,1,0, 4'b0000,32'h00000000,16'd0,1,1,0));
    steps.push_back(mk(0,0,16'd0,0,W1,1,0, 4'b0001,32'h00000000,16'd1,1,1,0));
    steps.push_back(mk(0,0,16'd0,1,W2,1,0, 4'b0010,32'h00000100,16'd1,1,1,0));
    steps.push_back(mk(0,0,16'd0,0,0, 1,0, 4'b0101,32'h00020020,16'd2,0,1,0));
    steps.push_back(mk(0,0,16'd0,0,0, 1,0, 4'b1010,32'h03002100,16'd2,0,1,0));
    steps.push_back(mk(0,0,16'd0,0,0, 1,0, 4'b0100,32'h00220000,16'd2,0,1,0));
    steps.push_back(mk(0,0,16'd0,0,0, 1,0, 4'b1000,32'h23000000,16'd2,0,0,1));
    steps.push_back(mk(0,0,16'd0,0,0, 1,0, 4'b0000,32'h00000000,16'd2,0,0,0));
    foreach (steps[k]) begin
      drive(steps[k]);
      @(negedge clk);
      n_checks++;
      if ({bus_if.o_row_vld, bus_if.o_row_data} !== {steps[k].ev, steps[k].ed}) begin
        n_fail++;
        $display("FAIL lfsr_bubbles lanes cyc %0d: got vld=%b data=%h, want vld=%b data=%h",
                 k, bus_if.o_row_vld, bus_if.o_row_data, steps[k].ev, steps[k].ed);
      end
      n_checks++;
      if ({bus_if.o_vec_cnt, bus_if.o_lfsr_en, bus_if.o_busy, bus_if.o_done} !==
          {steps[k].ec, steps[k].een, steps[k].eb, steps[k].edn}) begin
        n_fail++;
        $display("FAIL lfsr_bubbles ctrl cyc %0d: got cnt=%0d en=%b busy=%b done=%b, want cnt=%0d en=%b busy=%b done=%b",
                 k, bus_if.o_vec_cnt, bus_if.o_lfsr_en, bus_if.o_busy, bus_if.o_done,
                 steps[k].ec, steps[k].een, steps[k].eb, steps[k].edn);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_early_stop();
    steps = {};
    steps.push_back(mk(0,1,16'd10,0,0, 1,0, 4'b0000,32'h00000000,16'd2,0,0,0));
    steps.push_back(mk(0,0,16'd0,1,W0,1,0,  4'b0000,32'h00000000,16'd0,1,1,0));
    steps.push_back(mk(0,0,16'd0,1,W1,1,0,  4'b0001,32'h00000000,16'd1,1,1,0));
    steps.push_back(mk(0,0,16'd0,1,W2,1,0,  4'b0011,32'h00000110,16'd2,1,1,0));
    steps.push_back(mk(0,0,16'd0,1,W3,1,1,  4'b0111,32'h00021120,16'd3,1,1,0));
    steps.push_back(mk(0,0,16'd0,1,W0,1,1,  4'b1111,32'h03122130,16'd4,0,1,0));
    steps.push_back(mk(0,0,16'd0,1,W0,1,0,  4'b1110,32'h13223100,16'd4,0,1,0));
    steps.push_back(mk(0,0,16'd0,1,W0,1,0,  4'b1100,32'h23320000,16'd4,0,1,0));
    steps.push_back(mk(0,0,16'd0,1,W0,1,0,  4'b1000,32'h33000000,16'd4,0,0,1));
    steps.push_back(mk(0,0,16'd0,0,0, 1,0,  4'b0000,32'h00000000,16'd4,0,0,0));
    foreach (steps[k]) begin
      drive(steps[k]);
      @(negedge clk);
      n_checks++;
      if ({bus_if.o_row_vld, bus_if.o_row_data} !== {steps[k].ev, steps[k].ed}) begin
        n_fail++;
        $display("FAIL early_stop lanes cyc %0d: got vld=%b data=%h, want vld=%b data=%h",
                 k, bus_if.o_row_vld, bus_if.o_row_data, steps[k].ev, steps[k].ed);
      end
      n_checks++;
      if ({bus_if.o_vec_cnt, bus_if.o_lfsr_en, bus_if.o_busy, bus_if.o_done} !==
          {steps[k].ec, steps[k].een, steps[k].eb, steps[k].edn}) begin
        n_fail++;
        $display("FAIL early_stop ctrl cyc %0d: got cnt=%0d en=%b busy=%b done=%b, want cnt=%0d en=%b busy=%b done=%b",
                 k, bus_if.o_vec_cnt, bus_if.o_lfsr_en, bus_if.o_busy, bus_if.o_done,
                 steps[k].ec, steps[k].een, steps[k].eb, steps[k].edn);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_and_ignored_start();
    steps = {};
    steps.push_back(mk(0,1,16'd0,1,W0,1,0, 4'b0000,32'h00000000,16'd4,0,0,0));
    steps.push_back(mk(0,0,16'd0,1,W0,1,0, 4'b0000,32'h00000000,16'd0,0,0,1));
    steps.push_back(mk(0,0,16'd0,0,0, 1,0, 4'b0000,32'h00000000,16'd0,0,0,0));
    steps.push_back(mk(0,1,16'd2,0,0, 1,0, 4'b0000,32'h00000000,16'd0,0,0,0));
    steps.push_back(mk(0,0,16'd0,1,W0,1,0, 4'b0000,32'h00000000,16'd0,1,1,0));
    steps.push_back(mk(0,1,16'd5,1,W1,1,0, 4'b0001,32'h00000000,16'd1,1,1,0));
    steps.push_back(mk(0,0,16'd0,1,W2,1,0, 4'b0011,32'h00000110,16'd2,0,1,0));
    steps.push_back(mk(0,0,16'd0,1,W2,1,0, 4'b0110,32'h00021100,16'd2,0,1,0));
    steps.push_back(mk(0,0,16'd0,1,W2,1,0, 4'b1100,32'h03120000,16'd2,0,1,0));
    steps.push_back(mk(0,1,16'd5,1,W2,1,0, 4'b1000,32'h13000000,16'd2,0,0,1));
    steps.push_back(mk(0,0,16'd0,0,0, 1,0, 4'b0000,32'h00000000,16'd2,0,0,0));
    steps.push_back(mk(0,0,16'd0,0,0, 1,0, 4'b0000,32'h00000000,16'd2,0,0,0));
    foreach (steps[k]) begin
      drive(steps[k]);
      @(negedge clk);
      n_checks++;
      if ({bus_if.o_row_vld, bus_if.o_row_data} !== {steps[k].ev, steps[k].ed}) begin
        n_fail++;
        $display("FAIL zero_ignored lanes cyc %0d: got vld=%b data=%h, want vld=%b data=%h",
                 k, bus_if.o_row_vld, bus_if.o_row_data, steps[k].ev, steps[k].ed);
      end
      n_checks++;
      if ({bus_if.o_vec_cnt, bus_if.o_lfsr_en, bus_if.o_busy, bus_if.o_done} !==
          {steps[k].ec, steps[k].een, steps[k].eb, steps[k].edn}) begin
        n_fail++;
        $display("FAIL zero_ignored ctrl cyc %0d: got cnt=%0d en=%b busy=%b done=%b, want cnt=%0d en=%b busy=%b done=%b",
                 k, bus_if.o_vec_cnt, bus_if.o_lfsr_en, bus_if.o_busy, bus_if.o_done,
                 steps[k].ec, steps[k].een, steps[k].eb, steps[k].edn);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_burst();
    steps = {};
    steps.push_back(mk(0,1,16'd5,0,0, 1,0, 4'b0000,32'h00000000,16'd2,0,0,0));
    steps.push_back(mk(0,0,16'd0,1,W0,1,0, 4'b0000,32'h00000000,16'd0,1,1,0));
    steps.push_back(mk(0,0,16'd0,1,W1,1,0, 4'b0001,32'h00000000,16'd1,1,1,0));
    steps.push_back(mk(1,1,16'd3,1,W2,1,0, 4'b0011,32'h00000110,16'd2,1,1,0));
    steps.push_back(mk(0,0,16'd0,1,W3,1,0, 4'b0000,32'h00000000,16'd0,0,0,0));
    steps.push_back(mk(0,1,16'd1,0,0, 1,0, 4'b0000,32'h00000000,16'd0,0,0,0));
    steps.push_back(mk(0,0,16'd0,1,W0,1,0, 4'b0000,32'h00000000,16'd0,1,1,0));
    steps.push_back(mk(0,0,16'd0,1,W1,1,0, 4'b0001,32'h00000000,16'd1,0,1,0));
    steps.push_back(mk(0,0,16'd0,1,W1,1,0, 4'b0010,32'h00000100,16'd1,0,1,0));
    steps.push_back(mk(0,0,16'd0,1,W1,1,0, 4'b0100,32'h00020000,16'd1,0,1,0));
    steps.push_back(mk(0,0,16'd0,1,W1,1,0, 4'b1000,32'h03000000,16'd1,0,0,1));
    steps.push_back(mk(0,0,16'd0,0,0, 1,0, 4'b0000,32'h00000000,16'd1,0,0,0));
    foreach (steps[k]) begin
      drive(steps[k]);
      @(negedge clk);
      n_checks++;
      if ({bus_if.o_row_vld, bus_if.o_row_data} !== {steps[k].ev, steps[k].ed}) begin
        n_fail++;
        $display("FAIL reset_mid lanes cyc %0d: got vld=%b data=%h, want vld=%b data=%h",
                 k, bus_if.o_row_vld, bus_if.o_row_data, steps[k].ev, steps[k].ed);
      end
      n_checks++;
      if ({bus_if.o_vec_cnt, bus_if.o_lfsr_en, bus_if.o_busy, bus_if.o_done} !==
          {steps[k].ec, steps[k].een, steps[k].eb, steps[k].edn}) begin
        n_fail++;
        $display("FAIL reset_mid ctrl cyc %0d: got cnt=%0d en=%b busy=%b done=%b, want cnt=%0d en=%b busy=%b done=%b",
                 k, bus_if.o_vec_cnt, bus_if.o_lfsr_en, bus_if.o_busy, bus_if.o_done,
                 steps[k].ec, steps[k].een, steps[k].eb, steps[k].edn);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    drive(mk(1, 0, 16'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    test_reset();
    test_basic_skew();
    test_backpressure();
    test_lfsr_bubbles();
    test_early_stop();
    test_zero_and_ignored_start();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
